// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: register map,
// CTRL bit layout, mode encodings, FSM state encoding and bus base address.
// No logic; imported by timer_dev.
package timer_dev_pkg;

    // Word offsets within the device window
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode encodings (1x is treated as one-shot)
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Base address the bridge decodes for this device
    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_7F00;

    // Architectural view of the CTRL word, MSB first
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Zero-extend the CTRL fields to a bus word
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Countdown timer on the data-memory bus; IRQ = IM & pending. Macro TIMER_AUTORELOAD_EN adds mode 01 auto-reload.
// Latency: register writes take effect at the WE edge; reads are combinational; IRQ rises PRESET+3 edges after enable.
// Backpressure: none; the device accepts a write every cycle and never stalls the memory stage.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              IRQ
);

    logic        en;
    logic        im;
    logic [1:0]  mode_rd;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;
    logic [1:0]  state;
    ctrl_t       ctrl_rd;

    logic sel_ctrl;
    logic sel_preset;
    logic sel_count;
    logic wr_ctrl;
    logic wr_preset;

    assign sel_ctrl   = (Addr == ADDR_W'(REG_CTRL));
    assign sel_preset = (Addr == ADDR_W'(REG_PRESET));
    assign sel_count  = (Addr == ADDR_W'(REG_COUNT));
    assign wr_ctrl    = WE && sel_ctrl;
    assign wr_preset  = WE && sel_preset;

`ifdef TIMER_AUTORELOAD_EN
    logic [1:0] mode;
    logic       reload;

    assign mode_rd = mode;
    assign reload  = (mode == MODE_RELOAD);

    // Mode field storage; only present when auto-reload is built in
    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= MODE_ONESHOT;
        end else if (wr_ctrl) begin
            mode <= WriteData[CTRL_MODE_HI:CTRL_MODE_LO];
        end
    end
`else
    logic reload;

    assign mode_rd = MODE_ONESHOT;
    assign reload  = 1'b0;
`endif

    // FSM plus CTRL/PRESET registers; a CTRL write is applied last so it overrides the FSM's own en/pending updates
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count == 32'd0) begin
                        state   <= ST_INT;
                        pending <= 1'b1;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                ST_INT: begin
                    if (reload) begin
                        // pending lives only for the INT cycle in auto-reload
                        state   <= ST_LOAD;
                        pending <= 1'b0;
                    end else begin
                        en    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (wr_ctrl) begin
                en      <= WriteData[CTRL_EN];
                im      <= WriteData[CTRL_IM];
                pending <= 1'b0;
            end

            if (wr_preset) begin
                preset <= WriteData;
            end
        end
    end

    assign ctrl_rd = {im, mode_rd, en};

    // Load data mux; reserved and out-of-map addresses read as zero
    always_comb begin
        ReadData = '0;
        if (sel_ctrl) begin
            ReadData = ctrl_word(ctrl_rd);
        end else if (sel_preset) begin
            ReadData = preset;
        end else if (sel_count) begin
            ReadData = count;
        end
    end

    assign IRQ = im & pending;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed vectors with literal expectations,
// plus a time-based reference model compared against ReadData/IRQ every cycle.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        IRQ;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    timer_dev #(.ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WE        (WE),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: m_run counts edges since the enabling edge was seen
    // while idle (1 = load edge pending), m_p is the preset latched at load.
    bit          m_en, m_im, m_pend;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_cnt;
    longint      m_run, m_p;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_en = 0; m_im = 0; m_pend = 0; m_mode = 2'b00;
            m_preset = 0; m_cnt = 0; m_run = 0; m_p = 0;
        end else begin
            if (m_run == 0) begin
                if (m_en) m_run = 1;
            end else begin
                m_run++;
                if (m_run == 2) begin
                    m_p   = longint'(m_preset);
                    m_cnt = m_preset;
                end else if (m_run <= m_p + 3) begin
                    if (!m_en)                m_run = 0;
                    else if (m_run == m_p + 3) m_pend = 1;
                    else                       m_cnt = 32'(m_p - (m_run - 2));
                end else begin
                    if (AR && m_mode == 2'b01) begin
                        m_run  = 1;
                        m_pend = 0;
                    end else begin
                        m_en  = 0;
                        m_run = 0;
                    end
                end
            end
            if (WE && Addr == 2'd0) begin
                m_en   = WriteData[0];
                m_im   = WriteData[3];
                m_mode = AR ? WriteData[2:1] : 2'b00;
                m_pend = 0;
            end
            if (WE && Addr == 2'd1) m_preset = WriteData;
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_rd",  ReadData, m_read(Addr));
            check("model_irq", {31'd0, IRQ}, {31'd0, m_im & m_pend});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1; Addr = a; WriteData = d;
        tick(1);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        Addr = a;
        #1;
        check(name, ReadData, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; WE = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    bit hi [0:40];
    int rises;

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = 2'd0; WriteData = 32'd0;
        tick(1);
        chk_on = 1;
        tick(1);
        reset = 1'b0;

        // reset state
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        rd(2'd3, 32'd0, "rst_rsvd");
        check("rst_irq", {31'd0, IRQ}, 32'd0);

        // one-shot, PRESET=3: IRQ rises 6 edges after the enabling write
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(2); rd(2'd2, 32'd3, "os_cnt3");
        tick(1); rd(2'd2, 32'd2, "os_cnt2");
        tick(1); rd(2'd2, 32'd1, "os_cnt1");
        tick(1); rd(2'd2, 32'd0, "os_cnt0");
        check("os_irq_e5", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("os_irq_e6", {31'd0, IRQ}, 32'd1);
        tick(3);
        rd(2'd0, 32'h8, "os_ctrl_after");
        check("os_irq_held", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);
        check("os_irq_cleared", {31'd0, IRQ}, 32'd0);

        // PRESET=0: IRQ rises 3 edges after enable
        do_reset();
        wr(2'd0, 32'h9);
        tick(2);
        check("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("p0_irq_e3", {31'd0, IRQ}, 32'd1);

        // auto-reload: period PRESET+3, PRESET change applies after next reload
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
        for (int k = 1; k <= 35; k++) begin
            if (k == 18) begin
                WE = 1'b1; Addr = 2'd1; WriteData = 32'd4;
            end else begin
                WE = 1'b0; Addr = 2'd2;
            end
            tick(1);
            hi[k] = IRQ;
        end
        WE = 1'b0;
        rises = 0;
        for (int k = 1; k <= 35; k++) if (hi[k] && !hi[k-1]) rises++;
        check("ar_rise_count", rises, 6);
        check("ar_p1_hi", {31'd0, hi[5]},  32'd1);  check("ar_p1_lo", {31'd0, hi[6]},  32'd0);
        check("ar_p2_hi", {31'd0, hi[10]}, 32'd1);  check("ar_p2_lo", {31'd0, hi[11]}, 32'd0);
        check("ar_p3_hi", {31'd0, hi[15]}, 32'd1);  check("ar_p3_lo", {31'd0, hi[16]}, 32'd0);
        check("ar_p4_hi", {31'd0, hi[20]}, 32'd1);
        check("ar_p5_hi", {31'd0, hi[27]}, 32'd1);
        check("ar_p6_hi", {31'd0, hi[34]}, 32'd1);
`else
        rd(2'd0, 32'h9, "noar_ctrl_mode_dropped");
`endif

        // stop mid-count at COUNT=6, freeze, then restart from PRESET
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(6); rd(2'd2, 32'd6, "stop_cnt6");
        wr(2'd0, 32'h8);
        rd(2'd2, 32'd5, "stop_frozen_a");
        tick(5);
        rd(2'd2, 32'd5, "stop_frozen_b");
        check("stop_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h9);
        tick(2); rd(2'd2, 32'd10, "stop_restart");

        // collision: CTRL write in the INT cycle of a one-shot
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick(4);
        check("col_irq_int", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h9);
        rd(2'd0, 32'h9, "col_ctrl");
        check("col_irq_clear", {31'd0, IRQ}, 32'd0);
        tick(2); rd(2'd2, 32'd1, "col_reload");
        tick(2);
        check("col_irq_again", {31'd0, IRQ}, 32'd1);

        // reset mid-count, then ignored writes
        do_reset();
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        tick(5); rd(2'd2, 32'd5, "mid_cnt5");
        do_reset();
        rd(2'd0, 32'd0, "mid_rst_ctrl");
        rd(2'd1, 32'd0, "mid_rst_preset");
        rd(2'd2, 32'd0, "mid_rst_count");
        rd(2'd3, 32'd0, "mid_rst_rsvd");
        check("mid_rst_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd2, 32'h55);
        wr(2'd3, 32'hAA);
        rd(2'd2, 32'd0, "ign_count");
        rd(2'd3, 32'd0, "ign_rsvd");
        rd(2'd1, 32'd0, "ign_preset");
        rd(2'd0, 32'd0, "ign_ctrl");

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds to the CPU's data-memory store/load port. It sits beside the data memory behind the address decoder and decodes word writes and reads. It counts down from a programmed preset and raises an interrupt request line toward the CPU. It is the responder on the bus for which the pipeline's memory stage is the initiator.

## Interface
Parameters:
- `ADDR_W`, default 2, width of the word-select address (three registers used, one reserved).

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Addr`  input  `ADDR_W`  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `WE`  input  1  write enable; asserted only in cycles in which the decoder selects this device.
- `WriteData`  input  32  store data.
- `ReadData`  output  32  load data; combinational from `Addr`.
- `IRQ`  output  1  interrupt request, equal to `IM & pending`.

## Operation
- **CTRL register:**
  - bit0 Enable.
  - bits[2:1] Mode: 00 one-shot, 01 auto-reload, 1x behaves as 00.
  - bit3 IM (interrupt mask, 1 = unmasked).
  - bits[31:4] read as 0 and ignore writes.
- **PRESET:** full 32-bit read/write.
- **COUNT:** read-only; writes are ignored.
- **Reserved address:** reads return 0; writes are ignored.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: Enable=1 → LOAD. Otherwise stay; COUNT is held.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT: Enable=0 → IDLE with COUNT held. Otherwise, COUNT==0 → INT and pending ← 1. Otherwise COUNT ← COUNT−1.
  - INT, mode 00: Enable ← 0, → IDLE. `pending` stays set until any CTRL write.
  - INT, mode 01: → LOAD. `pending` is cleared on exit from INT, so it is a one-cycle pulse.
- **Effect of a CTRL write:** it always clears `pending`.
  - Writing Enable=0 during CNT stops counting at the next edge.
  - Re-enabling from IDLE reloads PRESET.
- **Effect of a PRESET write:** takes effect at the next LOAD only; it does not disturb the count in progress.
- **Simultaneous CTRL write and INT:** if the CPU writes CTRL in the same cycle the FSM is in INT, the CPU's written value wins for all CTRL bits. The FSM still takes its transition, and `pending` ends cleared.
- **Reset:** clears all of the following at the next edge, including mid-count:
  - CTRL, PRESET, COUNT and `pending` ← 0.
  - State ← IDLE.
  - `IRQ` = 0.
- **Arithmetic:** COUNT is unsigned 32-bit. The decrement never wraps, because 0 exits via INT.

## Timing
- Writes are registered at the edge where `WE`=1. Reads are same-cycle combinational and show register contents as of the last edge.
- **One-shot latency:** `IRQ` rises PRESET+3 edges after the CTRL-write edge that sets Enable (assuming IM=1).
- **Auto-reload:** `IRQ` pulses 1 cycle high every PRESET+3 cycles.
- **PRESET=0:** `IRQ` rises 3 edges after enable.
- **IM=0:** `pending` still sets and is visible through `IRQ` as soon as IM is written to 1. Note that this same CTRL write clears `pending`, so software polls COUNT instead.
- **Output reset values:** `ReadData` = 0 for every address; `IRQ` = 0.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: mode 01 implements auto-reload as specified above.
- `TIMER_AUTORELOAD_EN` undefined:
  - CTRL bits[2:1] are not stored and read as 0.
  - Every expiry behaves as one-shot.
  - The INT→LOAD path is absent.

## Structure
- **Shared package:**
  - Register word offsets: CTRL=0, PRESET=1, COUNT=2.
  - CTRL bit positions: EN=0, MODE=2:1, IM=3.
  - Mode encodings.
  - 2-bit FSM state encoding.
  - The bridge's base-address constant for this device.
- **Single module:** no sub-module; the register file and FSM are tightly coupled.

## Test plan
- **Reset state:** apply reset, then read all four addresses → all return 0; `IRQ`=0.
- **One-shot expiry:**
  - Stimulus: PRESET←3, then CTRL←0x9.
  - COUNT reads 3, 2, 1, 0 on successive cycles after LOAD.
  - `IRQ` rises exactly 6 edges after the CTRL write.
  - Afterwards CTRL reads 0x8 and `IRQ` stays high.
  - A subsequent CTRL←0x8 drops `IRQ`.
- **Auto-reload:**
  - Stimulus: PRESET←2, then CTRL←0xB.
  - `IRQ` produces 1-cycle pulses 5 cycles apart, at least three times.
  - Writing PRESET←4 mid-count changes the period to 7 only after the next reload.
- **Stop mid-count:**
  - Stimulus: PRESET←10, CTRL←0x9, then CTRL←0x8 while COUNT=6.
  - COUNT freezes at the value reached; `IRQ` never rises.
  - Re-enabling restarts from 10.
- **Collision:** CTRL←0x9 written in the INT cycle of a one-shot → CTRL reads 0x9, `pending`=0, and a new count from PRESET begins.
- **Reset mid-count, plus ignored writes:**
  - Assert reset while COUNT=5 → all registers read 0 next cycle; `IRQ`=0.
  - Writes to COUNT and to the reserved address have no effect.
